// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, redirect flush,
// downstream-stall hold and saturating event counters.
module id_ex_pipe (
    input  logic        clk,
    input  logic        rst,

    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [16:0] id_ctrl,

    input  logic        ex_redirect,
    input  logic        mem_stall,

    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1_addr,
    output logic [4:0]  ex_rs2_addr,
    output logic [4:0]  ex_rd_addr,
    output logic [16:0] ex_ctrl,

    output logic        id_stall,
    output logic [15:0] load_use_cnt,
    output logic [15:0] flush_cnt
);

    // Decoder bundle bit positions used by the hazard logic.
    localparam int unsigned CTRL_MEM_WE = 12;
    localparam int unsigned CTRL_MEM_RD = 11;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic ex_load;
    logic rd_match;
    logic load_use;

    // Hazard detection: a real load in EX whose non-x0 destination is read by ID.
    // Stores also raise the read enable, so the write enable excludes them.
    always_comb begin
        ex_load  = ex_valid & ex_ctrl[CTRL_MEM_RD] & ~ex_ctrl[CTRL_MEM_WE];
        rd_match = (ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr);
        load_use = id_valid & ex_load & (ex_rd_addr != 5'd0) & rd_match;
        // A redirect kills the ID instruction anyway, so fetch need not hold.
        id_stall = (mem_stall | load_use) & ~ex_redirect;
    end

    // EX slot register: flush > hold > bubble > capture, one action per edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rd_addr  <= '0;
            ex_ctrl     <= '0;
        end else if (ex_redirect || (!mem_stall && load_use)) begin
            // Flush and bubble both leave an empty slot with all enables low.
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rd_addr  <= '0;
            ex_ctrl     <= '0;
        end else if (!mem_stall) begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1_addr <= id_rs1_addr;
            ex_rs2_addr <= id_rs2_addr;
            ex_rd_addr  <= id_rd_addr;
            // An invalid slot must never carry live enables into EX.
            ex_ctrl     <= id_valid ? id_ctrl : '0;
        end
        // NOTE: with mem_stall and no redirect no branch assigns, so the flops
        // simply hold; this is a clocked block, so no latch is implied.
    end

    // Saturating event counters: one flush per redirect edge, one per bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt    <= '0;
            load_use_cnt <= '0;
        end else if (ex_redirect) begin
            if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 16'd1;
        end else if (!mem_stall && load_use) begin
            if (load_use_cnt != CNT_MAX) load_use_cnt <= load_use_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: a reference model predicts the EX slot
// after every edge, the driver queues the prediction, a monitor pops and compares.
module tb_id_ex_pipe;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [16:0] ctrl;
        logic        redirect;
        logic        mstall;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  rd;
        logic [16:0] ctrl;
        logic [15:0] luc;
        logic [15:0] fc;
    } obs_t;

    logic clk;
    logic rst;
    in_t  stim;

    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [16:0] ex_ctrl;
    logic        id_stall;
    logic [15:0] load_use_cnt, flush_cnt;

    id_ex_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (stim.valid),
        .id_pc       (stim.pc),
        .id_rs1_addr (stim.a1),
        .id_rs2_addr (stim.a2),
        .id_rd_addr  (stim.rd),
        .id_rs1_data (stim.d1),
        .id_rs2_data (stim.d2),
        .id_imm      (stim.imm),
        .id_ctrl     (stim.ctrl),
        .ex_redirect (stim.redirect),
        .mem_stall   (stim.mstall),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_imm      (ex_imm),
        .ex_rs1_addr (ex_rs1_addr),
        .ex_rs2_addr (ex_rs2_addr),
        .ex_rd_addr  (ex_rd_addr),
        .ex_ctrl     (ex_ctrl),
        .id_stall    (id_stall),
        .load_use_cnt(load_use_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_mis = 0;
    obs_t model;
    obs_t exp_q[$];

    function automatic obs_t dut_obs();
        return {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_ctrl,
                load_use_cnt, flush_cnt};
    endfunction

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what EX should hold after the next edge, from the rules.
    function automatic obs_t predict(input obs_t cur, input in_t s, output logic stall);
        obs_t nxt;
        logic is_load, hazard;
        is_load = cur.valid && cur.ctrl[11] && !cur.ctrl[12];
        hazard  = s.valid && is_load && cur.rd != 0 && (cur.rd == s.a1 || cur.rd == s.a2);
        stall   = (s.mstall || hazard) && !s.redirect;
        nxt     = cur;
        if (s.redirect) begin
            nxt     = '0;
            nxt.luc = cur.luc;
            nxt.fc  = (cur.fc == 16'hFFFF) ? cur.fc : cur.fc + 16'd1;
        end else if (s.mstall) begin
            nxt = cur;
        end else if (hazard) begin
            nxt     = '0;
            nxt.fc  = cur.fc;
            nxt.luc = (cur.luc == 16'hFFFF) ? cur.luc : cur.luc + 16'd1;
        end else begin
            nxt.valid = s.valid;
            nxt.pc    = s.pc;
            nxt.d1    = s.d1;
            nxt.d2    = s.d2;
            nxt.imm   = s.imm;
            nxt.a1    = s.a1;
            nxt.a2    = s.a2;
            nxt.rd    = s.rd;
            nxt.ctrl  = s.valid ? s.ctrl : 17'd0;
        end
        return nxt;
    endfunction

    // Drive one cycle of inputs, check the combinational stall, queue the prediction.
    task automatic apply(input in_t s);
        logic exp_stall;
        @(negedge clk);
        stim = s;
        #1;
        model = predict(model, s, exp_stall);
        check("id_stall", 200'(id_stall), 200'(exp_stall));
        exp_q.push_back(model);
    endtask

    // Pulse reset between edges, check immediate clear, then queue the first capture.
    task automatic pulse_reset(input in_t after);
        logic dummy;
        @(negedge clk);
        #2 rst = 1'b1;
        stim = '0;
        #1;
        check("reset_clear", 200'({dut_obs(), id_stall}), 200'(0));
        #1 rst = 1'b0;
        exp_q.delete();
        model = '0;
        stim  = after;
        model = predict(model, after, dummy);
        exp_q.push_back(model);
    endtask

    function automatic in_t rand_in();
        in_t s;
        s.valid    = ($urandom_range(0, 9) != 0);
        s.pc       = $urandom;
        s.a1       = 5'($urandom_range(0, 3));
        s.a2       = 5'($urandom_range(0, 3));
        s.rd       = 5'($urandom_range(0, 3));
        s.d1       = $urandom;
        s.d2       = $urandom;
        s.imm      = $urandom;
        s.ctrl     = 17'($urandom);
        if ($urandom_range(0, 1) == 0) begin
            s.ctrl[11] = 1'b1;
            s.ctrl[12] = ($urandom_range(0, 3) == 0);
        end
        s.redirect = ($urandom_range(0, 9) == 0);
        s.mstall   = ($urandom_range(0, 4) == 0);
        return s;
    endfunction

    function automatic in_t instr(input logic [31:0] pc, input logic [4:0] a1,
                                  input logic [4:0] a2, input logic [4:0] rd,
                                  input logic [16:0] ctrl);
        in_t s;
        s          = '0;
        s.valid    = 1'b1;
        s.pc       = pc;
        s.a1       = a1;
        s.a2       = a2;
        s.rd       = rd;
        s.d1       = pc ^ 32'hA5A5_0000;
        s.d2       = pc ^ 32'h0000_5A5A;
        s.imm      = pc + 32'd4;
        s.ctrl     = ctrl;
        return s;
    endfunction

    // Monitor: after each edge compare the DUT's EX slot with the oldest prediction.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ex_slot", 200'(dut_obs()), 200'(e));
            end
        end
    end

    localparam logic [16:0] LW  = 17'h02800;   // regWrite + memRDEN2
    localparam logic [16:0] SW  = 17'h05800;   // store + memWE2 + memRDEN2

    initial begin
        in_t s;
        rst   = 1'b1;
        stim  = '0;
        model = '0;
        repeat (2) @(posedge clk);

        // Reset release followed by the basic capture.
        pulse_reset(instr(32'h100, 5'd1, 5'd2, 5'd3, 17'h02600));
        apply(instr(32'h104, 5'd0, 5'd0, 5'd0, 17'h00000));

        // Load-use: lw x5 then a reader of x5 through rs2, then the reader again.
        apply(instr(32'h200, 5'd1, 5'd2, 5'd5, LW));
        apply(instr(32'h204, 5'd7, 5'd5, 5'd6, 17'h02000));
        apply(instr(32'h204, 5'd7, 5'd5, 5'd6, 17'h02000));

        // Store with rd field 5 followed by a reader of x5: no hazard.
        apply(instr(32'h300, 5'd1, 5'd2, 5'd5, SW));
        apply(instr(32'h304, 5'd5, 5'd1, 5'd4, 17'h02000));

        // Load to x0 followed by a reader of x0: no hazard.
        apply(instr(32'h400, 5'd1, 5'd2, 5'd0, LW));
        apply(instr(32'h404, 5'd0, 5'd3, 5'd4, 17'h02000));

        // Redirect, stall and load-use together: flush wins.
        apply(instr(32'h500, 5'd1, 5'd2, 5'd9, LW));
        s = instr(32'h504, 5'd9, 5'd0, 5'd1, 17'h02000);
        s.redirect = 1'b1;
        s.mstall   = 1'b1;
        apply(s);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) apply(rand_in());

        // Reset during a held stall discards the held slot.
        s = instr(32'h600, 5'd1, 5'd2, 5'd3, LW);
        apply(s);
        s.mstall = 1'b1;
        apply(s);
        apply(s);
        pulse_reset(instr(32'h700, 5'd3, 5'd3, 5'd8, 17'h02600));

        // Flush counter saturation: 65536 redirects plus a few more.
        s = '0;
        s.redirect = 1'b1;
        for (int i = 0; i < 65540; i++) apply(s);
        apply(instr(32'h800, 5'd1, 5'd2, 5'd3, 17'h02600));

        // Final reset pulse clears everything immediately.
        pulse_reset(instr(32'h900, 5'd1, 5'd2, 5'd3, 17'h02600));

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
